// File: rtl/regfile_wb_queue.sv
// ============================================================================
// regfile_wb_queue
// ----------------------------------------------------------------------------
// Write-back buffer in front of the 32x32 register file. Accepts write-back
// requests from the ALU (priority) and the load path, holds them in an
// in-order FIFO and drains one entry per cycle into the single regfile write
// port. A combinational lookup reports whether a decode source register still
// has a write in flight, and optionally forwards the youngest matching data.
//
// Parameters
//   DEPTH          FIFO entries, power of two, 2..16 (default 4)
//
// Build option
//   WBQ_FORWARD_EN when defined, FwdData1/FwdData2 carry the data of the
//                  youngest queued entry matching LookupReg1/LookupReg2;
//                  when undefined they are tied to zero and no select logic
//                  is built.
//
// Ports
//   Clk, ResetN                  clock, asynchronous active-low reset
//   AluValid/AluReg/AluData      ALU write-back request
//   AluReady                     ALU request accepted this cycle
//   MemValid/MemReg/MemData      load write-back request
//   MemReady                     load request accepted this cycle
//   WbHold                       regfile write port unavailable, no drain
//   WriteRegister/WriteData      head entry to the regfile (0 when empty)
//   RegWrite                     regfile write enable
//   LookupReg1/LookupReg2        decode source registers
//   Pending1/Pending2            a queued write targets that register
//   FwdData1/FwdData2            forwarded data (see build option)
//   Count                        current occupancy
//
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_wb_queue #(
  parameter int DEPTH = 4
) (
  input  logic                     Clk,
  input  logic                     ResetN,
  // ALU write-back request
  input  logic                     AluValid,
  input  logic [4:0]               AluReg,
  input  logic [31:0]              AluData,
  output logic                     AluReady,
  // Load write-back request
  input  logic                     MemValid,
  input  logic [4:0]               MemReg,
  input  logic [31:0]              MemData,
  output logic                     MemReady,
  // Regfile write port
  input  logic                     WbHold,
  output logic [4:0]               WriteRegister,
  output logic [31:0]              WriteData,
  output logic                     RegWrite,
  // Decode lookup
  input  logic [4:0]               LookupReg1,
  input  logic [4:0]               LookupReg2,
  output logic                     Pending1,
  output logic                     Pending2,
  output logic [31:0]              FwdData1,
  output logic [31:0]              FwdData2,
  // Status
  output logic [$clog2(DEPTH):0]   Count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);

  // --------------------------------------------------------------------------
  // Storage
  // --------------------------------------------------------------------------
  logic [4:0]        ent_reg   [DEPTH];
  logic [31:0]       ent_data  [DEPTH];
  logic [DEPTH-1:0]  ent_valid;
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [CNT_W-1:0]  count;

  // --------------------------------------------------------------------------
  // Handshake and enqueue selection
  // --------------------------------------------------------------------------
  logic        full;
  logic        empty;
  logic        alu_fire;
  logic        mem_fire;
  logic [4:0]  enq_reg;
  logic [31:0] enq_data;
  logic        do_push;
  logic        do_pop;

  assign full  = (count == FULL_COUNT);
  assign empty = (count == '0);

  // Readiness depends only on registered occupancy (and AluValid for the
  // load path), so a drain in the same cycle never opens a slot for an
  // enqueue. Both are held low while reset is asserted.
  assign AluReady = ResetN && !full;
  assign MemReady = ResetN && !full && !AluValid;

  assign alu_fire = AluValid && AluReady;
  assign mem_fire = MemValid && MemReady;

  assign enq_reg  = alu_fire ? AluReg  : MemReg;
  assign enq_data = alu_fire ? AluData : MemData;

  // Writes to x0 complete the handshake but are discarded.
  assign do_push = (alu_fire || mem_fire) && (enq_reg != 5'd0);
  assign do_pop  = !empty && !WbHold;

  // --------------------------------------------------------------------------
  // FIFO state
  // --------------------------------------------------------------------------
  // A push and pop never target the same slot: a push needs !full and a pop
  // needs !empty, so with 0 < count < DEPTH the head and tail always differ.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      ent_valid <= '0;
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_reg[i]  <= '0;
        ent_data[i] <= '0;
      end
    end else begin
      if (do_pop) begin
        ent_valid[head] <= 1'b0;
        head            <= head + PTR_ONE;
      end
      if (do_push) begin
        ent_valid[tail] <= 1'b1;
        ent_reg[tail]   <= enq_reg;
        ent_data[tail]  <= enq_data;
        tail            <= tail + PTR_ONE;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Regfile write port
  // --------------------------------------------------------------------------
  // Popped slots keep their old contents, so the head is masked when empty.
  assign RegWrite      = do_pop;
  assign WriteRegister = empty ? 5'd0  : ent_reg[head];
  assign WriteData     = empty ? 32'd0 : ent_data[head];
  assign Count         = count;

  // --------------------------------------------------------------------------
  // Pending lookup (head being written this cycle still counts)
  // --------------------------------------------------------------------------
  logic hit1;
  logic hit2;

  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_valid[i] && (ent_reg[i] == LookupReg1)) hit1 = 1'b1;
      if (ent_valid[i] && (ent_reg[i] == LookupReg2)) hit2 = 1'b1;
    end
  end

  assign Pending1 = hit1 && (LookupReg1 != 5'd0);
  assign Pending2 = hit2 && (LookupReg2 != 5'd0);

  // --------------------------------------------------------------------------
  // Forwarding
  // --------------------------------------------------------------------------
`ifdef WBQ_FORWARD_EN
  logic [31:0] fwd1;
  logic [31:0] fwd2;

  // Walk from oldest (head) to youngest; a later match overrides an earlier
  // one, so the tail-most matching entry wins.
  always_comb begin
    logic [PTR_W-1:0] idx;
    fwd1 = 32'd0;
    fwd2 = 32'd0;
    idx  = head;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PTR_W'(i);
      if (ent_valid[idx] && (LookupReg1 != 5'd0) && (ent_reg[idx] == LookupReg1))
        fwd1 = ent_data[idx];
      if (ent_valid[idx] && (LookupReg2 != 5'd0) && (ent_reg[idx] == LookupReg2))
        fwd2 = ent_data[idx];
    end
  end

  assign FwdData1 = fwd1;
  assign FwdData2 = fwd2;
`else
  assign FwdData1 = 32'd0;
  assign FwdData2 = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_regfile_wb_queue.sv
// ============================================================================
// tb_regfile_wb_queue
// ----------------------------------------------------------------------------
// Directed self-checking bench for regfile_wb_queue (DEPTH = 4). Inputs are
// driven 1 ns after the rising edge; outputs are compared in the same window,
// well away from the next active edge.
//
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_wb_queue;

  localparam int DEPTH = 4;

  logic        Clk;
  logic        ResetN;
  logic        AluValid;
  logic [4:0]  AluReg;
  logic [31:0] AluData;
  logic        AluReady;
  logic        MemValid;
  logic [4:0]  MemReg;
  logic [31:0] MemData;
  logic        MemReady;
  logic        WbHold;
  logic [4:0]  WriteRegister;
  logic [31:0] WriteData;
  logic        RegWrite;
  logic [4:0]  LookupReg1;
  logic [4:0]  LookupReg2;
  logic        Pending1;
  logic        Pending2;
  logic [31:0] FwdData1;
  logic [31:0] FwdData2;
  logic [$clog2(DEPTH):0] Count;

  int n_checks;
  int n_fails;

  regfile_wb_queue #(.DEPTH(DEPTH)) dut (
    .Clk           (Clk),
    .ResetN        (ResetN),
    .AluValid      (AluValid),
    .AluReg        (AluReg),
    .AluData       (AluData),
    .AluReady      (AluReady),
    .MemValid      (MemValid),
    .MemReg        (MemReg),
    .MemData       (MemData),
    .MemReady      (MemReady),
    .WbHold        (WbHold),
    .WriteRegister (WriteRegister),
    .WriteData     (WriteData),
    .RegWrite      (RegWrite),
    .LookupReg1    (LookupReg1),
    .LookupReg2    (LookupReg2),
    .Pending1      (Pending1),
    .Pending2      (Pending2),
    .FwdData1      (FwdData1),
    .FwdData2      (FwdData2),
    .Count         (Count)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check_value(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock and settle into the drive/sample window.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  logic [4:0]  exp_reg  [5];
  logic [31:0] exp_data [5];
  logic [31:0] exp_fwd;

  initial begin
    n_checks   = 0;
    n_fails    = 0;
    ResetN     = 1'b0;
    AluValid   = 1'b0;
    AluReg     = '0;
    AluData    = '0;
    MemValid   = 1'b0;
    MemReg     = '0;
    MemData    = '0;
    WbHold     = 1'b0;
    LookupReg1 = '0;
    LookupReg2 = '0;

    // ---------------- reset state ----------------
    step();
    check_value("rst_regwrite", {31'd0, RegWrite}, 32'd0);
    check_value("rst_count",    {29'd0, Count},    32'd0);
    check_value("rst_aluready", {31'd0, AluReady}, 32'd0);
    check_value("rst_memready", {31'd0, MemReady}, 32'd0);
    check_value("rst_wreg",     {27'd0, WriteRegister}, 32'd0);
    ResetN = 1'b1;
    step();

    // ---------------- single ALU write, minimum latency ----------------
    AluValid = 1'b1; AluReg = 5'd2; AluData = 32'd42;
    LookupReg1 = 5'd2;
    #1;
    check_value("t1_aluready", {31'd0, AluReady}, 32'd1);
    check_value("t1_pend_pre", {31'd0, Pending1}, 32'd0);
    step();
    AluValid = 1'b0;
    #1;
    check_value("t1_regwrite", {31'd0, RegWrite}, 32'd1);
    check_value("t1_wreg",     {27'd0, WriteRegister}, 32'd2);
    check_value("t1_wdata",    WriteData, 32'd42);
    check_value("t1_count",    {29'd0, Count}, 32'd1);
    check_value("t1_pending",  {31'd0, Pending1}, 32'd1);
    step();
    check_value("t1_count_end", {29'd0, Count}, 32'd0);
    check_value("t1_idle",      {31'd0, RegWrite}, 32'd0);
    LookupReg1 = 5'd0;

    // ---------------- fill under hold, then ordered drain ----------------
    WbHold = 1'b1;
    for (int k = 0; k < 4; k++) begin
      AluValid = 1'b1; AluReg = 5'(3 + k); AluData = 32'(10 + k);
      #1;
      check_value("t2_fill_ready", {31'd0, AluReady}, 32'd1);
      step();
    end
    AluReg = 5'd7; AluData = 32'd14;   // fifth request, must stall
    #1;
    check_value("t2_full_count", {29'd0, Count},    32'd4);
    check_value("t2_full_alurd", {31'd0, AluReady}, 32'd0);
    check_value("t2_full_memrd", {31'd0, MemReady}, 32'd0);
    check_value("t2_hold_nowr",  {31'd0, RegWrite}, 32'd0);
    step();
    check_value("t2_stall_count", {29'd0, Count}, 32'd4);

    exp_reg[0] = 5'd3; exp_data[0] = 32'd10;
    exp_reg[1] = 5'd4; exp_data[1] = 32'd11;
    exp_reg[2] = 5'd5; exp_data[2] = 32'd12;
    exp_reg[3] = 5'd6; exp_data[3] = 32'd13;
    exp_reg[4] = 5'd7; exp_data[4] = 32'd14;
    WbHold = 1'b0;
    #1;
    // Draining does not free a slot in the same cycle.
    check_value("t2_rel_alurd", {31'd0, AluReady}, 32'd0);
    for (int k = 0; k < 5; k++) begin
      check_value("t2_drain_we",   {31'd0, RegWrite}, 32'd1);
      check_value("t2_drain_reg",  {27'd0, WriteRegister}, {27'd0, exp_reg[k]});
      check_value("t2_drain_data", WriteData, exp_data[k]);
      if (k == 1) check_value("t2_slot_free", {31'd0, AluReady}, 32'd1);
      step();
      if (k == 1) AluValid = 1'b0;
      #1;
    end
    check_value("t2_empty_count", {29'd0, Count},    32'd0);
    check_value("t2_empty_we",    {31'd0, RegWrite}, 32'd0);

    // ---------------- ALU priority over load ----------------
    WbHold = 1'b1;
    AluValid = 1'b1; AluReg = 5'd8;  AluData = 32'd1;
    MemValid = 1'b1; MemReg = 5'd9;  MemData = 32'd2;
    #1;
    check_value("t3_c1_alurd", {31'd0, AluReady}, 32'd1);
    check_value("t3_c1_memrd", {31'd0, MemReady}, 32'd0);
    step();
    AluReg = 5'd10; AluData = 32'd3;
    #1;
    check_value("t3_c2_memrd", {31'd0, MemReady}, 32'd0);
    check_value("t3_c2_count", {29'd0, Count},    32'd1);
    step();
    AluValid = 1'b0;
    #1;
    check_value("t3_c3_memrd", {31'd0, MemReady}, 32'd1);
    step();
    MemValid = 1'b0;
    check_value("t3_count", {29'd0, Count}, 32'd3);
    WbHold = 1'b0;
    #1;
    check_value("t3_w0_reg", {27'd0, WriteRegister}, 32'd8);
    step();
    check_value("t3_w1_reg", {27'd0, WriteRegister}, 32'd10);
    check_value("t3_w1_dat", WriteData, 32'd3);
    step();
    check_value("t3_w2_reg", {27'd0, WriteRegister}, 32'd9);
    check_value("t3_w2_dat", WriteData, 32'd2);
    step();
    check_value("t3_end_count", {29'd0, Count}, 32'd0);

    // ---------------- write to x0 is dropped ----------------
    AluValid = 1'b1; AluReg = 5'd0; AluData = 32'd12;
    #1;
    check_value("t4_alurd", {31'd0, AluReady}, 32'd1);
    step();
    AluValid = 1'b0;
    check_value("t4_count", {29'd0, Count},    32'd0);
    check_value("t4_nowr",  {31'd0, RegWrite}, 32'd0);
    step();
    check_value("t4_nowr2", {31'd0, RegWrite}, 32'd0);

    // ---------------- pending / forwarding ----------------
    WbHold = 1'b1;
    LookupReg1 = 5'd17; LookupReg2 = 5'd2;
    AluValid = 1'b1; AluReg = 5'd17; AluData = 32'd47;
    step();
`ifdef WBQ_FORWARD_EN
    exp_fwd = 32'd47;
`else
    exp_fwd = 32'd0;
`endif
    check_value("t5_fwd_one", FwdData1, exp_fwd);
    AluData = 32'd99;
    step();
    AluReg = 5'd5; AluData = 32'd7;
    #1;
`ifdef WBQ_FORWARD_EN
    exp_fwd = 32'd99;
`else
    exp_fwd = 32'd0;
`endif
    check_value("t5_pend1", {31'd0, Pending1}, 32'd1);
    check_value("t5_pend2", {31'd0, Pending2}, 32'd0);
    check_value("t5_fwd1",  FwdData1, exp_fwd);
    check_value("t5_fwd2",  FwdData2, 32'd0);
    step();
    AluValid = 1'b0;
    check_value("t5_count3", {29'd0, Count}, 32'd3);

    // ---------------- asynchronous reset mid-drain ----------------
    WbHold = 1'b0;
    step();
    check_value("t6_draining", {31'd0, RegWrite}, 32'd1);
    check_value("t6_pend_pre", {31'd0, Pending1}, 32'd1);
    #2;
    ResetN = 1'b0;
    #1;
    check_value("t6_rst_we",    {31'd0, RegWrite}, 32'd0);
    check_value("t6_rst_count", {29'd0, Count},    32'd0);
    check_value("t6_rst_pend1", {31'd0, Pending1}, 32'd0);
    check_value("t6_rst_alurd", {31'd0, AluReady}, 32'd0);
    check_value("t6_rst_wdata", WriteData, 32'd0);
    check_value("t6_rst_fwd1",  FwdData1, 32'd0);
    step();
    ResetN = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      check_value("t6_no_stale_we", {31'd0, RegWrite}, 32'd0);
      check_value("t6_post_count",  {29'd0, Count},    32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fails);
    $finish;
  end

endmodule

`default_nettype wire
